core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Run/halt sequencer for the single-cycle core. Owns the datapath's clock-enable (core_en) and synchronous datapath reset (core_rst).
- Holds the core in reset after power-up and parks it in HALTED.
- Accepts host commands (run, halt, step N, breakpoints, core reset) over a valid/ready port.
- Halts precisely, before executing, on a PC breakpoint or a software-break opcode.

Parameters:
- BOOT_HOLD, 4, cycles core_rst is held after reset release or RESET_CORE (min 1).
- CNT_W, 32, width of cycle/retired counters and step count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP0, 5 SET_BP1, 6 CLR_BP, 7 RESET_CORE.
- cmd_data  in  32  BP address / step count (low CNT_W bits) / CLR_BP mask (bits[1:0]).
- pc  in  32  current PC from datapath.
- instruction  in  32  current fetched instruction.
- core_en  out  1  datapath enable; PC, register file and data-memory writes are gated by it.
- core_rst  out  1  synchronous reset to datapath.
- state  out  3  0 BOOT, 1 HALTED, 2 RUN, 3 STEP.
- halt_cause  out  2  0 HOST, 1 BP, 2 STEP_DONE, 3 SWBRK.
- bp_hit  out  1  one-cycle pulse on entry to HALTED due to a breakpoint.
- cycle_cnt  out  CNT_W  cycles spent outside BOOT.
- retired_cnt  out  CNT_W  cycles with core_en=1.

Behaviour:
- Reset (async, reset=1):
  - state=BOOT, boot counter=0, core_rst=1, core_en=0, cmd_ready=0.
  - halt_cause=0, bp_hit=0, both BPs disabled with address 0.
  - cycle_cnt=0, retired_cnt=0, step counter=0, skip flag=0.
- BOOT:
  - core_rst=1 and core_en=0 for exactly BOOT_HOLD clock edges after reset release, then HALTED with core_rst=0.
  - cmd_ready=0. Counters do not increment.
- cmd_ready = (state != BOOT). Each accepted command takes effect at the next edge.
- Breakpoint and software-break matching:
  - bp_match = (bp0_en & pc==bp0_addr) | (bp1_en & pc==bp1_addr).
  - swbrk = (instruction[31:26]==6'b111111).
- core_en (combinational):
  - RUN: 1 unless (bp_match & !skip) or swbrk.
  - STEP: same rule.
  - All other states: 0.
  - A halting condition therefore blocks the matching instruction from executing.
- skip flag:
  - Set when entering RUN or STEP from HALTED.
  - Cleared after the first core_en=1 cycle.
  - Resuming from a breakpoint PC executes that instruction once. swbrk is never skipped.
- HALTED:
  - RUN → RUN.
  - STEP → STEP with step counter = max(cmd_data,1).
  - HALT and NOP: no effect.
- RUN:
  - HALT → HALTED, cause HOST. The instruction in the accept cycle still executes.
  - bp_match & !skip → HALTED, cause BP, bp_hit=1 for one cycle.
  - swbrk → HALTED, cause SWBRK.
  - RUN/STEP while in RUN or STEP: accepted, ignored.
- STEP:
  - Step counter decrements on each core_en=1 cycle. On the cycle it is decremented to 0 → HALTED, cause STEP_DONE.
  - BP, SWBRK and HOST halts apply as in RUN.
- Halt-cause priority when several hold in one cycle: BP > SWBRK > STEP_DONE > HOST.
- SET_BP0/1: load the address and enable that BP. Allowed in any non-BOOT state.
- CLR_BP: disable each BP whose mask bit is 1.
- RESET_CORE (any non-BOOT state):
  - → BOOT, boot counter restarts, cycle_cnt and retired_cnt cleared.
  - Breakpoint registers and halt_cause retained.
  - Highest priority over any same-cycle halt.
- Counters:
  - cycle_cnt +1 every cycle state != BOOT.
  - retired_cnt +1 every cycle core_en=1.
  - Both wrap modulo 2^CNT_W.
- bp_hit is registered. It is 0 in every cycle except the first HALTED cycle after a BP halt.
- Reset asserted mid-RUN/STEP: immediate BOOT, all state cleared as above.

Test Plan:
- Reset release, BOOT_HOLD=4 → core_rst=1 for 4 edges, then state=1, core_en=0, cmd_ready=1, cycle_cnt starts at 0.
- SET_BP0 0x0000000C; RUN; pc steps 0,4,8,0xC → core_en=0 at pc=0xC, state=HALTED, halt_cause=1, bp_hit single pulse, retired_cnt=3.
- From that halt, RUN → instruction at 0xC executes (skip). pc reaching 0xC again later halts again.
- STEP cmd_data=2 from HALTED → exactly 2 core_en cycles, halt_cause=2. STEP cmd_data=0 → exactly 1.
- RUN then instruction=0xFC000000 → core_en=0 in that cycle, halt_cause=3, retired_cnt unchanged.
- HALT in RUN same cycle as bp_match → halt_cause=1. RESET_CORE in RUN → BOOT, counters 0, BP still enabled afterwards. Async reset mid-STEP → immediate state=0, core_rst=1.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run/halt sequencer for the single-cycle core: owns the datapath clock-enable
// and synchronous reset, and halts precisely on breakpoints, soft-breaks and step completion.
module core_run_ctrl #(
  parameter int BOOT_HOLD = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  input  logic [31:0]      pc,
  input  logic [31:0]      instruction,
  output logic             core_en,
  output logic             core_rst,
  output logic [2:0]       state,
  output logic [1:0]       halt_cause,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  // Command port: a command is consumed on any edge where cmd_valid & cmd_ready;
  // cmd_ready depends only on state, never on cmd_valid.
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_HALTED = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3
  } state_t;

  localparam logic [1:0] HC_HOST  = 2'd0;
  localparam logic [1:0] HC_BP    = 2'd1;
  localparam logic [1:0] HC_STEP  = 2'd2;
  localparam logic [1:0] HC_SWBRK = 2'd3;

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_SETBP0 = 3'd4;
  localparam logic [2:0] OP_SETBP1 = 3'd5;
  localparam logic [2:0] OP_CLRBP  = 3'd6;
  localparam logic [2:0] OP_RESET  = 3'd7;

  localparam int            BW        = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_HOLD - 1);

  state_t             state_q, state_d;
  logic [BW-1:0]      boot_q, boot_d;
  logic [1:0]         cause_q, cause_d;
  logic               bp_hit_q, bp_hit_d;
  logic               bp0_en_q, bp0_en_d, bp1_en_q, bp1_en_d;
  logic [31:0]        bp0_addr_q, bp0_addr_d, bp1_addr_q, bp1_addr_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d, retired_q, retired_d, step_q, step_d;
  logic               skip_q, skip_d;

  logic               cmd_fire, bp_match, swbrk, running, bp_halt;
  logic [CNT_W-1:0]   step_load;
  logic               unused_instr;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign bp_match  = (bp0_en_q & (pc == bp0_addr_q)) | (bp1_en_q & (pc == bp1_addr_q));
  assign swbrk     = (instruction[31:26] == 6'b111111);
  assign running   = (state_q == ST_RUN) || (state_q == ST_STEP);
  // The skip flag lets a resume from a breakpoint PC execute that instruction once.
  assign bp_halt   = bp_match & ~skip_q;
  assign core_en   = running & ~(bp_halt | swbrk);
  assign step_load = (cmd_data[CNT_W-1:0] == '0) ? CNT_W'(1) : cmd_data[CNT_W-1:0];
  assign unused_instr = ^instruction[25:0];

  assign cmd_ready   = (state_q != ST_BOOT);
  assign core_rst    = (state_q == ST_BOOT);
  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;

  always_comb begin
    state_d    = state_q;
    boot_d     = boot_q;
    cause_d    = cause_q;
    bp_hit_d   = 1'b0;
    bp0_en_d   = bp0_en_q;
    bp1_en_d   = bp1_en_q;
    bp0_addr_d = bp0_addr_q;
    bp1_addr_d = bp1_addr_q;
    step_d     = step_q;
    skip_d     = skip_q;
    cycle_d    = (state_q != ST_BOOT) ? cycle_q + CNT_W'(1) : cycle_q;
    retired_d  = core_en ? retired_q + CNT_W'(1) : retired_q;

    case (state_q)
      ST_BOOT: begin
        if (boot_q == BOOT_LAST) state_d = ST_HALTED;
        else                     boot_d  = boot_q + BW'(1);
      end
      ST_HALTED: begin
        if (cmd_fire && cmd_op == OP_RUN) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (cmd_fire && cmd_op == OP_STEP) begin
          state_d = ST_STEP;
          step_d  = step_load;
          skip_d  = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        if (core_en) skip_d = 1'b0;
        if (state_q == ST_STEP && core_en) step_d = step_q - CNT_W'(1);
        // Halt-cause priority: BP > SWBRK > STEP_DONE > HOST.
        if (bp_halt) begin
          state_d  = ST_HALTED;
          cause_d  = HC_BP;
          bp_hit_d = 1'b1;
        end else if (swbrk) begin
          state_d = ST_HALTED;
          cause_d = HC_SWBRK;
        end else if (state_q == ST_STEP && core_en && step_q == CNT_W'(1)) begin
          state_d = ST_HALTED;
          cause_d = HC_STEP;
        end else if (cmd_fire && cmd_op == OP_HALT) begin
          state_d = ST_HALTED;
          cause_d = HC_HOST;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (cmd_fire) begin
      case (cmd_op)
        OP_SETBP0: begin bp0_addr_d = cmd_data; bp0_en_d = 1'b1; end
        OP_SETBP1: begin bp1_addr_d = cmd_data; bp1_en_d = 1'b1; end
        OP_CLRBP: begin
          if (cmd_data[0]) bp0_en_d = 1'b0;
          if (cmd_data[1]) bp1_en_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Core reset overrides any same-cycle halt; breakpoints and cause survive it.
    if (cmd_fire && cmd_op == OP_RESET) begin
      state_d   = ST_BOOT;
      boot_d    = '0;
      cause_d   = cause_q;
      bp_hit_d  = 1'b0;
      skip_d    = 1'b0;
      cycle_d   = '0;
      retired_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_q     <= '0;
      cause_q    <= HC_HOST;
      bp_hit_q   <= 1'b0;
      bp0_en_q   <= 1'b0;
      bp1_en_q   <= 1'b0;
      bp0_addr_q <= '0;
      bp1_addr_q <= '0;
      cycle_q    <= '0;
      retired_q  <= '0;
      step_q     <= '0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_q     <= boot_d;
      cause_q    <= cause_d;
      bp_hit_q   <= bp_hit_d;
      bp0_en_q   <= bp0_en_d;
      bp1_en_q   <= bp1_en_d;
      bp0_addr_q <= bp0_addr_d;
      bp1_addr_q <= bp1_addr_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      step_q     <= step_d;
      skip_q     <= skip_d;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: per-cycle vector table (inputs + expected outputs) fed
// through an expected-value queue, plus an async-reset-mid-STEP sequence.
module tb_core_run_ctrl;

  localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, HALT = 3'd2, STEP = 3'd3;
  localparam logic [2:0] SBP0 = 3'd4, SBP1 = 3'd5, CLRB = 3'd6, RSTC = 3'd7;
  localparam logic [31:0] SWB = 32'hFC00_0000;

  typedef struct packed {
    logic [2:0]  st;
    logic        en;
    logic        rst;
    logic        rdy;
    logic [1:0]  hc;
    logic        bp;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    logic        val;
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  localparam int EW = $bits(exp_t);

  logic        clk, reset, cmd_valid, cmd_ready, core_en, core_rst, bp_hit;
  logic [2:0]  cmd_op, state;
  logic [31:0] cmd_data, pc, instruction, cycle_cnt, retired_cnt;
  logic [1:0]  halt_cause;

  logic [EW-1:0] exp_q[$];
  int n_cmp, n_bad;
  vec_t vecs[48];

  core_run_ctrl #(.BOOT_HOLD(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc), .instruction(instruction),
    .core_en(core_en), .core_rst(core_rst), .state(state), .halt_cause(halt_cause),
    .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1);
  end

  function automatic vec_t mkv(input logic val, input logic [2:0] op, input logic [31:0] data,
                               input logic [31:0] pcv, input logic [31:0] instr,
                               input logic [2:0] st, input logic en, input logic [1:0] hc,
                               input logic bp, input logic [31:0] cyc, input logic [31:0] ret);
    vec_t v;
    v.val = val; v.op = op; v.data = data; v.pc = pcv; v.instr = instr;
    v.e.st = st; v.e.en = en; v.e.hc = hc; v.e.bp = bp; v.e.cyc = cyc; v.e.ret = ret;
    v.e.rst = (st == 3'd0);
    v.e.rdy = (st != 3'd0);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop the oldest expectation and compare against current outputs.
  task automatic check_row(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s queue: got empty, expected an entry", tag);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    cmp({tag, " state"},       32'(state),       32'(e.st));
    cmp({tag, " core_en"},     32'(core_en),     32'(e.en));
    cmp({tag, " core_rst"},    32'(core_rst),    32'(e.rst));
    cmp({tag, " cmd_ready"},   32'(cmd_ready),   32'(e.rdy));
    cmp({tag, " halt_cause"},  32'(halt_cause),  32'(e.hc));
    cmp({tag, " bp_hit"},      32'(bp_hit),      32'(e.bp));
    cmp({tag, " cycle_cnt"},   cycle_cnt,        e.cyc);
    cmp({tag, " retired_cnt"}, retired_cnt,      e.ret);
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic run_row(input vec_t v, input string tag);
    @(negedge clk);
    cmd_valid   = v.val;
    cmd_op      = v.op;
    cmd_data    = v.data;
    pc          = v.pc;
    instruction = v.instr;
    exp_q.push_back(EW'(v.e));
    #1;
    check_row(tag);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0;
    pc = '0; instruction = '0;

    //                 val op    data   pc     instr  st en hc bp cyc ret
    vecs[0]  = mkv(0, NOP,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[1]  = mkv(0, NOP,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[2]  = mkv(1, RUN,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[3]  = mkv(0, NOP,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[4]  = mkv(1, SBP0, 'hC,   0,     0,     1, 0, 0, 0, 0,  0);
    vecs[5]  = mkv(1, RUN,  0,     0,     0,     1, 0, 0, 0, 1,  0);
    vecs[6]  = mkv(0, NOP,  0,     0,     0,     2, 1, 0, 0, 2,  0);
    vecs[7]  = mkv(0, NOP,  0,     4,     0,     2, 1, 0, 0, 3,  1);
    vecs[8]  = mkv(0, NOP,  0,     8,     0,     2, 1, 0, 0, 4,  2);
    vecs[9]  = mkv(0, NOP,  0,     'hC,   0,     2, 0, 0, 0, 5,  3);
    vecs[10] = mkv(0, NOP,  0,     'hC,   0,     1, 0, 1, 1, 6,  3);
    vecs[11] = mkv(1, RUN,  0,     'hC,   0,     1, 0, 1, 0, 7,  3);
    vecs[12] = mkv(0, NOP,  0,     'hC,   0,     2, 1, 1, 0, 8,  3);
    vecs[13] = mkv(0, NOP,  0,     'h10,  0,     2, 1, 1, 0, 9,  4);
    vecs[14] = mkv(0, NOP,  0,     'hC,   0,     2, 0, 1, 0, 10, 5);
    vecs[15] = mkv(1, STEP, 2,     'hC,   0,     1, 0, 1, 1, 11, 5);
    vecs[16] = mkv(0, NOP,  0,     'hC,   0,     3, 1, 1, 0, 12, 5);
    vecs[17] = mkv(0, NOP,  0,     'h10,  0,     3, 1, 1, 0, 13, 6);
    vecs[18] = mkv(1, STEP, 0,     'h14,  0,     1, 0, 2, 0, 14, 7);
    vecs[19] = mkv(0, NOP,  0,     'h14,  0,     3, 1, 2, 0, 15, 7);
    vecs[20] = mkv(1, RUN,  0,     'h18,  0,     1, 0, 2, 0, 16, 8);
    vecs[21] = mkv(0, NOP,  0,     'h18,  SWB,   2, 0, 2, 0, 17, 8);
    vecs[22] = mkv(1, RUN,  0,     'h18,  0,     1, 0, 3, 0, 18, 8);
    vecs[23] = mkv(0, NOP,  0,     'h18,  0,     2, 1, 3, 0, 19, 8);
    vecs[24] = mkv(1, HALT, 0,     'hC,   0,     2, 0, 3, 0, 20, 9);
    vecs[25] = mkv(1, RUN,  0,     'hC,   0,     1, 0, 1, 1, 21, 9);
    vecs[26] = mkv(1, HALT, 0,     'hC,   0,     2, 1, 1, 0, 22, 9);
    vecs[27] = mkv(1, RUN,  0,     'h10,  0,     1, 0, 0, 0, 23, 10);
    vecs[28] = mkv(1, RSTC, 0,     'h10,  0,     2, 1, 0, 0, 24, 10);
    vecs[29] = mkv(0, NOP,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[30] = mkv(0, NOP,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[31] = mkv(0, NOP,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[32] = mkv(0, NOP,  0,     0,     0,     0, 0, 0, 0, 0,  0);
    vecs[33] = mkv(1, RUN,  0,     0,     0,     1, 0, 0, 0, 0,  0);
    vecs[34] = mkv(0, NOP,  0,     0,     0,     2, 1, 0, 0, 1,  0);
    vecs[35] = mkv(0, NOP,  0,     4,     0,     2, 1, 0, 0, 2,  1);
    vecs[36] = mkv(0, NOP,  0,     8,     0,     2, 1, 0, 0, 3,  2);
    vecs[37] = mkv(0, NOP,  0,     'hC,   0,     2, 0, 0, 0, 4,  3);
    vecs[38] = mkv(1, CLRB, 1,     'hC,   0,     1, 0, 1, 1, 5,  3);
    vecs[39] = mkv(1, RUN,  0,     'hC,   0,     1, 0, 1, 0, 6,  3);
    vecs[40] = mkv(0, NOP,  0,     'hC,   0,     2, 1, 1, 0, 7,  3);
    vecs[41] = mkv(0, NOP,  0,     'h10,  0,     2, 1, 1, 0, 8,  4);
    vecs[42] = mkv(1, SBP1, 'h20,  'hC,   0,     2, 1, 1, 0, 9,  5);
    vecs[43] = mkv(0, NOP,  0,     'h20,  0,     2, 0, 1, 0, 10, 6);
    vecs[44] = mkv(1, RUN,  0,     'h20,  0,     1, 0, 1, 1, 11, 6);
    vecs[45] = mkv(0, NOP,  0,     'h20,  0,     2, 1, 1, 0, 12, 6);
    vecs[46] = mkv(1, HALT, 0,     'h24,  SWB,   2, 0, 1, 0, 13, 7);
    vecs[47] = mkv(0, NOP,  0,     'h24,  0,     1, 0, 3, 0, 14, 7);

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < 48; i++) run_row(vecs[i], $sformatf("row%0d", i));

    // Async reset in the middle of a multi-step run.
    run_row(mkv(1, STEP, 5, 'h24, 0, 1, 0, 3, 0, 15, 7), "step5_accept");
    run_row(mkv(0, NOP,  0, 'h24, 0, 3, 1, 3, 0, 16, 7), "step5_first");
    #2 reset = 1'b1;
    exp_q.push_back(EW'(mkv(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0).e));
    #1 check_row("async_reset");

    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++)
      run_row(mkv(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("reboot%0d", i));
    run_row(mkv(1, RUN, 0, 0,     0, 1, 0, 0, 0, 0, 0), "reboot_run");
    run_row(mkv(0, NOP, 0, 'h20,  0, 2, 1, 0, 0, 1, 0), "bp1_cleared");
    run_row(mkv(0, NOP, 0, 'hC,   0, 2, 1, 0, 0, 2, 1), "bp0_cleared");

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL queue_drain: got %0d entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
